pxs_frame_arbiter: RTL and testbench
====================================

PXS_FRAME_ARBITER -- requirements
Module: pxs_frame_arbiter

Interface
REQ-001 Parameter HOLD_FRAMES, default 2: minimum frame starts a grant is held while its owner still requests (range 1..15).
REQ-002 Parameter VSYNC_POL, default 1'b0: active level of VSync (0 = active-low, the VGA 640x480 convention).
REQ-003 px_clk  in  1  pixel clock; the block's only clock, and all logic SHALL be on its rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 RGBStr0_i..RGBStr3_i  in  26 each  source streams: RGB[25:23], XCoord[22:13], YCoord[12:3], HSync[2], VSync[1], ActiveVideo[0]; all four are timing-aligned and RGBStr0_i is the timing master.
REQ-006 req_i  in  4  per-source request, level-sensitive.
REQ-007 grant_o  out  4  one-hot owner, or all-zero when idle; registered.
REQ-008 RGBStr_o  out  26  arbitrated stream; registered.

Function
REQ-009 Frame start (FS) SHALL be the cycle in which RGBStr0_i VSync is at VSYNC_POL and the registered previous VSync sample is not.
REQ-010 States SHALL be IDLE (grant_o = 0) and OWNED (grant_o one-hot).
REQ-011 grant_o SHALL change only in the cycle after an FS; req_i changes at any other time SHALL take effect at the next FS.
REQ-012 IDLE at FS with any req_i bit set -> OWNED; grant goes to the first requester found scanning round-robin from rr_ptr upward, mod 4.
REQ-013 OWNED at FS with the owner's req_i low -> re-arbitrate as in REQ-012 among the remaining requesters, or go to IDLE if there are none.
REQ-014 OWNED at FS with the owner still requesting:
- hold_cnt < HOLD_FRAMES-1 -> increment hold_cnt, keep the grant;
- otherwise, if another source requests -> rotate to it per REQ-012;
- otherwise -> keep the grant and saturate hold_cnt.
REQ-015 On every grant change, hold_cnt SHALL clear to 0 and rr_ptr SHALL become (new owner index + 1) mod 4.
REQ-016 Latency from source stream to RGBStr_o SHALL be exactly 1 cycle.
REQ-017 In OWNED, RGBStr_o[22:0] SHALL be the owner stream's [22:0]; RGBStr_o[25:23] SHALL be the owner's RGB when its ActiveVideo = 1, else 3'b000.
REQ-018 In IDLE, RGBStr_o[22:0] SHALL be RGBStr0_i[22:0] and RGB SHALL be 3'b000.
REQ-019 Stream selection SHALL use the grant value registered for the current cycle, so the output source changes in the same cycle grant_o changes, one cycle after FS.
REQ-020 If FS and a req_i edge fall in the same cycle, the req_i value sampled in that FS cycle SHALL be the one used.
REQ-021 If VSync is held at its active level, no further FS SHALL occur until it has gone inactive and then active again.

Reset
REQ-022 While rst_n = 0: grant_o = 4'b0000, RGBStr_o = 26'd0, state = IDLE, rr_ptr = 0, hold_cnt = 0, previous-VSync register = ~VSYNC_POL.
REQ-023 Reset asserted mid-frame SHALL abandon the current grant immediately; after release, the first grant SHALL occur only at the next FS.

Configuration
REQ-024 Macro PXS_FRAME_ARBITER_STATS_EN, when defined, SHALL add output switch_cnt_o [7:0]:
- reset value 0;
- increments by 1 in the cycle grant_o changes to any value, including to idle;
- wraps from 255 to 0.
REQ-025 When PXS_FRAME_ARBITER_STATS_EN is undefined, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-026 Reset release, req_i = 4'b0100 asserted mid-frame -> grant_o stays 0 until the cycle after the first FS, then 4'b0100; RGBStr_o carries source 2 one cycle later.
REQ-027 HOLD_FRAMES = 2, req_i = 4'b0011 constant -> grant 0001, 0001, 0010, 0010, 0001 on successive FS.
REQ-028 Owner 0 drops req_i at FS-1 while req_i[3] = 1 -> grant_o = 4'b1000 the cycle after that FS, regardless of hold_cnt.
REQ-029 Owner with RGB = 3'b100 and ActiveVideo = 0 -> RGBStr_o RGB = 3'b000 while the sync and coordinate bits match the owner, delayed by 1 cycle.
REQ-030 rst_n pulsed low mid-frame while grant_o = 4'b0010 -> grant_o and RGBStr_o go to 0 asynchronously; the next grant goes to the lowest requester from index 0 at the next FS.
REQ-031 PXS_FRAME_ARBITER_STATS_EN defined, 256 grant changes -> switch_cnt_o reads 0; one further change -> reads 1.

Source files
------------

// File: rtl/pxs_frame_arbiter.sv
// ---------------------------------------------------------------------------
// pxs_frame_arbiter
//
// Purpose:
//   Four-way, frame-granular arbiter for timing-aligned pixel streams.
//   Ownership of the output stream can only move at a frame start, which is
//   detected as the VSync edge of the master stream (RGBStr0_i). The current
//   owner keeps the grant for at least HOLD_FRAMES frame starts while it
//   keeps requesting. After that it yields, round-robin, to another requester.
//   The selected stream is re-registered with one cycle of latency. Its RGB is
//   blanked outside ActiveVideo. With no owner, the master timing is passed
//   through with black RGB.
//
// Parameters:
//   HOLD_FRAMES  minimum frame starts a grant is held (1..15)
//   VSYNC_POL    active level of VSync (0 = active-low)
//
// Ports:
//   px_clk        pixel clock (rising edge)
//   rst_n         asynchronous active-low reset
//   RGBStr0_i..3  source streams {RGB[25:23], X[22:13], Y[12:3], HS, VS, AV}
//                 RGBStr0_i is the timing master
//   req_i         per-source request, level-sensitive
//   grant_o       registered one-hot owner, all-zero when idle
//   RGBStr_o      registered arbitrated stream
//   switch_cnt_o  (only with PXS_FRAME_ARBITER_STATS_EN) 8-bit wrapping count
//                 of grant changes
//
// Optional feature macro: PXS_FRAME_ARBITER_STATS_EN
// ---------------------------------------------------------------------------
module pxs_frame_arbiter #(
    parameter int   HOLD_FRAMES = 2,
    parameter logic VSYNC_POL   = 1'b0
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic [25:0] RGBStr0_i,
    input  logic [25:0] RGBStr1_i,
    input  logic [25:0] RGBStr2_i,
    input  logic [25:0] RGBStr3_i,
    input  logic [3:0]  req_i,
    output logic [3:0]  grant_o,
    output logic [25:0] RGBStr_o
`ifdef PXS_FRAME_ARBITER_STATS_EN
    ,
    output logic [7:0]  switch_cnt_o
`endif
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_OWNED = 1'b1;

    // Last hold_cnt value that still forces the owner to keep the grant.
    localparam logic [3:0] HOLD_MAX = 4'(HOLD_FRAMES - 1);

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // First set bit of mask, scanning upward from ptr (mod 4). The result is
    // one-hot, or zero when the mask is empty. Iterating from the far end
    // lets the closest candidate overwrite the others.
    function automatic logic [3:0] rr_pick(input logic [3:0] mask,
                                           input logic [1:0] ptr);
        logic [3:0] res;
        logic [1:0] idx;
        res = '0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (mask[idx]) begin
                res      = '0;
                res[idx] = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) begin
                idx = 2'(k);
            end
        end
        return idx;
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [0:0]  state_reg,      state_next;
    logic [3:0]  grant_reg,      grant_next;
    logic [1:0]  rr_ptr_reg,     rr_ptr_next;
    logic [3:0]  hold_cnt_reg,   hold_cnt_next;
    logic        vsync_prev_reg;
    logic [25:0] out_reg,        out_next;

    logic [25:0] str_arr [4];
    logic [25:0] masked_w [4];
    logic [25:0] sel_or;
    logic        fs_w;
    logic        owner_req;
    logic [3:0]  others_req;
    logic [3:0]  pick_all;
    logic [3:0]  pick_oth;
    logic        grant_change;

    assign str_arr[0] = RGBStr0_i;
    assign str_arr[1] = RGBStr1_i;
    assign str_arr[2] = RGBStr2_i;
    assign str_arr[3] = RGBStr3_i;

    // A frame start is the edge into the active VSync level. While VSync
    // stays active, the previous sample is also active, so the edge fires
    // only once.
    assign fs_w = (RGBStr0_i[1] == VSYNC_POL) && (vsync_prev_reg != VSYNC_POL);

    assign owner_req  = |(req_i & grant_reg);
    assign others_req = req_i & ~grant_reg;
    assign pick_all   = rr_pick(req_i, rr_ptr_reg);
    assign pick_oth   = rr_pick(others_req, rr_ptr_reg);

    // -----------------------------------------------------------------------
    // Arbitration: decisions are made only at a frame start, from the req_i
    // value present in that cycle.
    // -----------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        grant_next    = grant_reg;
        hold_cnt_next = hold_cnt_reg;
        rr_ptr_next   = rr_ptr_reg;

        if (fs_w) begin
            case (state_reg)
                ST_IDLE: begin
                    if (|req_i) begin
                        grant_next = pick_all;
                        state_next = ST_OWNED;
                    end
                end
                ST_OWNED: begin
                    if (!owner_req) begin
                        // The owner is not in req_i, so scanning the full
                        // mask covers only the remaining requesters.
                        if (|req_i) begin
                            grant_next = pick_all;
                        end else begin
                            grant_next = '0;
                            state_next = ST_IDLE;
                        end
                    end else if (hold_cnt_reg < HOLD_MAX) begin
                        hold_cnt_next = hold_cnt_reg + 4'd1;
                    end else if (|others_req) begin
                        grant_next = pick_oth;
                    end
                    // Otherwise the owner keeps the grant and hold_cnt stays
                    // saturated at HOLD_MAX.
                end
                default: begin
                    state_next = ST_IDLE;
                    grant_next = '0;
                end
            endcase
        end

        grant_change = (grant_next != grant_reg);
        if (grant_change) begin
            hold_cnt_next = '0;
            if (grant_next != 4'b0000) begin
                rr_ptr_next = onehot_idx(grant_next) + 2'd1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output stream selection. This uses the next grant, so the source
    // switches in the same cycle that grant_o changes.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_mask
            assign masked_w[gi] = grant_next[gi]
                ? {(str_arr[gi][0] ? str_arr[gi][25:23] : 3'b000), str_arr[gi][22:0]}
                : 26'd0;
        end
    endgenerate

    always_comb begin
        sel_or = '0;
        for (int k = 0; k < 4; k++) begin
            sel_or = sel_or | masked_w[k];
        end
        if (grant_next == 4'b0000) begin
            out_next = {3'b000, RGBStr0_i[22:0]};
        end else begin
            out_next = sel_or;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= '0;
            rr_ptr_reg     <= '0;
            hold_cnt_reg   <= '0;
            vsync_prev_reg <= ~VSYNC_POL;
            out_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            rr_ptr_reg     <= rr_ptr_next;
            hold_cnt_reg   <= hold_cnt_next;
            vsync_prev_reg <= RGBStr0_i[1];
            out_reg        <= out_next;
        end
    end

    assign grant_o  = grant_reg;
    assign RGBStr_o = out_reg;

`ifdef PXS_FRAME_ARBITER_STATS_EN
    logic [7:0] switch_cnt_reg;

    always_ff @(posedge px_clk or negedge rst_n) begin
        if (!rst_n) begin
            switch_cnt_reg <= '0;
        end else if (grant_change) begin
            switch_cnt_reg <= switch_cnt_reg + 8'd1;
        end
    end

    assign switch_cnt_o = switch_cnt_reg;
`endif

endmodule

// File: tb/tb_pxs_frame_arbiter.sv
module tb_pxs_frame_arbiter;

    localparam int   HOLD = 2;
    localparam logic POL  = 1'b0;
    localparam int   HT   = 8;          // pixels per line
    localparam int   VT   = 4;          // lines per frame
    localparam int   FT   = HT * VT;

    logic        px_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic [25:0] src [4];
    logic [3:0]  req    = 4'b0000;
    logic [3:0]  grant_o;
    logic [25:0] RGBStr_o;
`ifdef PXS_FRAME_ARBITER_STATS_EN
    logic [7:0]  switch_cnt_o;
`endif

    always #5 px_clk = ~px_clk;

    pxs_frame_arbiter #(.HOLD_FRAMES(HOLD), .VSYNC_POL(POL)) dut (
        .px_clk    (px_clk),
        .rst_n     (rst_n),
        .RGBStr0_i (src[0]),
        .RGBStr1_i (src[1]),
        .RGBStr2_i (src[2]),
        .RGBStr3_i (src[3]),
        .req_i     (req),
        .grant_o   (grant_o),
        .RGBStr_o  (RGBStr_o)
`ifdef PXS_FRAME_ARBITER_STATS_EN
        ,
        .switch_cnt_o (switch_cnt_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, expressed as plain integers
    int          m_owner;     // -1 = idle
    int          m_rr;
    int          m_hold;
    int          m_sw;
    logic        m_vprev;
    logic [3:0]  m_grant;
    logic [25:0] m_out;

    int          pix = FT - 1;
    logic        ovr_en  = 1'b0;
    int          ovr_src = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_from(input logic [3:0] mask, input int start);
        for (int k = 0; k < 4; k++) begin
            if (mask[(start + k) % 4]) return (start + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [25:0] expect_out(input int o);
        if (o < 0) return {3'b000, src[0][22:0]};
        return {(src[o][0] ? src[o][25:23] : 3'b000), src[o][22:0]};
    endfunction

    function automatic void model_reset();
        m_owner = -1; m_rr = 0; m_hold = 0; m_sw = 0;
        m_vprev = ~POL; m_grant = 4'b0000; m_out = 26'd0;
    endfunction

    // Evaluated at each rising edge on the inputs that were stable before it.
    function automatic void model_step();
        logic [3:0] mask;
        int c;
        bit fs;
        if (!rst_n) begin
            model_reset();
            return;
        end
        fs = (src[0][1] == POL) && (m_vprev != POL);
        m_vprev = src[0][1];
        if (fs) begin
            c = m_owner;
            if (m_owner < 0 || !req[m_owner]) begin
                c = first_from(req, m_rr);
            end else if (m_hold < HOLD - 1) begin
                m_hold++;
            end else begin
                mask = req;
                mask[m_owner] = 1'b0;
                c = first_from(mask, m_rr);
                if (c < 0) c = m_owner;
            end
            if (c != m_owner) begin
                m_owner = c;
                m_hold  = 0;
                if (c >= 0) m_rr = (c + 1) % 4;
                m_sw = (m_sw + 1) % 256;
                $display("frame start t=%0t req=%b -> owner %0d", $time, req, c);
            end
        end
        m_grant = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
        m_out   = expect_out(m_owner);
    endfunction

    task automatic drive_next();
        int x, y;
        pix = (pix + 1) % FT;
        x = pix % HT;
        y = pix / HT;
        src[0] = {3'($urandom), 10'(x), 10'(y), (x >= HT - 2) ? 1'b0 : 1'b1,
                  (y == 0) ? POL : ~POL, (x < HT - 3 && y >= 1) ? 1'b1 : 1'b0};
        for (int k = 1; k < 4; k++) begin
            src[k] = {3'($urandom), 10'($urandom), 10'($urandom), src[0][2], src[0][1],
                      1'($urandom)};
        end
        if (ovr_en) begin
            src[ovr_src][25:23] = 3'b100;
            src[ovr_src][0]     = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge px_clk);
        model_step();
        #1;
        chk("grant", {28'd0, grant_o}, {28'd0, m_grant});
        chk("stream", {6'd0, RGBStr_o}, {6'd0, m_out});
`ifdef PXS_FRAME_ARBITER_STATS_EN
        chk("switch_cnt", {24'd0, switch_cnt_o}, 32'(m_sw));
`endif
        drive_next();
    endtask

    task automatic run_to_pix(input int p);
        int guard = 0;
        while (pix != p && guard < 4 * FT) begin
            tick();
            guard++;
        end
        chk("pix_reached", 32'(pix), 32'(p));
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_async_grant", {28'd0, grant_o}, 32'd0);
        chk("rst_async_stream", {6'd0, RGBStr_o}, 32'd0);
    endtask

    task automatic do_reset();
        assert_reset();
        tick();
        tick();
        run_to_pix(12);
        rst_n = 1'b1;
    endtask

    logic [3:0]  exp27 [5];
    logic [25:0] saved;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        drive_next();
        exp27[0] = 4'b0001; exp27[1] = 4'b0001; exp27[2] = 4'b0010;
        exp27[3] = 4'b0010; exp27[4] = 4'b0001;

        // Reset state and first grant only at the first frame start.
        do_reset();
        req = 4'b0100;
        while (pix != 0) begin
            tick();
            chk("idle_before_fs", {28'd0, grant_o}, 32'd0);
        end
        saved = src[2];
        tick();
        chk("first_grant", {28'd0, grant_o}, 32'b0100);
        chk("first_stream_lo", {9'd0, RGBStr_o[22:0]}, {9'd0, saved[22:0]});

        // Hold and round-robin rotation with two constant requesters.
        do_reset();
        req = 4'b0011;
        for (int f = 0; f < 5; f++) begin
            run_to_pix(0);
            tick();
            chk("rotation", {28'd0, grant_o}, {28'd0, exp27[f]});
        end

        // Owner 0 drops its request one cycle before a frame start.
        do_reset();
        req = 4'b1001;
        run_to_pix(0);
        tick();
        chk("owner0", {28'd0, grant_o}, 32'b0001);
        run_to_pix(FT - 1);
        req = 4'b1000;
        tick();
        tick();
        chk("drop_to_3", {28'd0, grant_o}, 32'b1000);

        // RGB is blanked while the owner's ActiveVideo is low.
        ovr_src = 3;
        ovr_en  = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            saved = src[3];
            tick();
            chk("rgb_blank", {29'd0, RGBStr_o[25:23]}, 32'd0);
            chk("blank_lo", {9'd0, RGBStr_o[22:0]}, {9'd0, saved[22:0]});
        end
        ovr_en = 1'b0;

        // Reset pulse mid-frame while source 1 owns the stream.
        do_reset();
        req = 4'b0010;
        run_to_pix(0);
        tick();
        chk("owner1", {28'd0, grant_o}, 32'b0010);
        run_to_pix(14);
        assert_reset();
        tick();
        req = 4'b0110;
        tick();
        rst_n = 1'b1;
        run_to_pix(0);
        tick();
        chk("post_reset_grant", {28'd0, grant_o}, 32'b0010);

        // Randomized request traffic, checked each cycle against the model.
        for (int i = 0; i < 40 * FT; i++) begin
            if ($urandom_range(0, 15) == 0) req = 4'($urandom_range(0, 15));
            tick();
        end

`ifdef PXS_FRAME_ARBITER_STATS_EN
        // Switch counter wraps after 256 grant changes.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            req = (n % 2 == 0) ? 4'b0001 : 4'b0000;
            run_to_pix(0);
            tick();
        end
        chk("switch_wrap", {24'd0, switch_cnt_o}, 32'd0);
        req = 4'b0001;
        run_to_pix(0);
        tick();
        chk("switch_after_wrap", {24'd0, switch_cnt_o}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
